ahb_cmd_master: RTL and testbench
=================================

AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning AHB data bus width in bits (32 only).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning AHB address width in bits.
REQ-003 HCLK  input  1  the single clock; all state SHALL change on its rising edge.
REQ-004 HRESETn  input  1  reset; asynchronous assertion, active-low.
REQ-005 CREQ  input  1  command request, held until accepted.
REQ-006 CACK  output  1  command accepted this cycle (combinational).
REQ-007 CWRITE  input  1  1 = write, 0 = read.
REQ-008 CADDR  input  ADDR_WIDTH  byte address.
REQ-009 CSIZE  input  3  transfer size (000 byte, 001 half, 010 word).
REQ-010 CWDATA  input  DATA_WIDTH  write data, sampled at acceptance.
REQ-011 RVALID  output  1  one-cycle response pulse.
REQ-012 RDATA  output  DATA_WIDTH  read data; 0 for writes.
REQ-013 RERROR  output  1  transfer ended with AHB ERROR.
REQ-014 HADDR  output  ADDR_WIDTH;  HTRANS  output  2;  HWRITE  output  1;  HSIZE  output  3.
REQ-015 HBURST  output  3  constant 000 (SINGLE);  HMASTLOCK  output  1  constant 0;  HPROT  output  4  constant 0011.
REQ-016 HWDATA  output  DATA_WIDTH;  HRDATA  input  DATA_WIDTH;  HREADY  input  1;  HRESP  input  1.

Function
REQ-017 Each accepted command SHALL be issued as one NONSEQ single transfer; HTRANS SHALL be IDLE (00) otherwise.
REQ-018 State SHALL consist of an address-phase slot (A) and a data-phase slot (D), each with a valid bit.
REQ-019 CACK SHALL equal CREQ & ~hold & (~A.valid | HREADY).
REQ-020 On an edge with CACK=1, A SHALL load CADDR, CWRITE, CSIZE, CWDATA; HADDR/HWRITE/HSIZE/HTRANS SHALL reflect A in the next cycle.
REQ-021 On an edge with HREADY=1, A SHALL move to D (D.valid <= A.valid & ~hold), and A.valid SHALL clear unless CACK=1 reloads it.
REQ-022 While D.valid, HWDATA SHALL drive D's write data; otherwise HWDATA SHALL hold its last value.
REQ-023 Back-to-back commands SHALL issue with zero idle cycles (new address phase overlaps previous data phase).
REQ-024 HADDR, HWRITE, HSIZE and HWDATA SHALL be stable while HREADY=0, except as in REQ-026.
REQ-025 On an edge with D.valid & HREADY=1, RVALID SHALL pulse next cycle with RERROR=HRESP, RDATA=HRDATA for reads and 0 for writes.
REQ-026 On HRESP=1 & HREADY=0 with D.valid (first error cycle), hold SHALL set; while hold, HTRANS SHALL be IDLE, A contents retained.
REQ-027 hold SHALL clear on the edge completing the error (HREADY=1); the retained A transfer SHALL reissue as NONSEQ the following cycle.
REQ-028 Wait states (HREADY=0) SHALL be unbounded; no timeout.
REQ-029 Responses SHALL return in command order; at most two commands outstanding.
REQ-030 Alignment SHALL NOT be checked; CSIZE>010 SHALL be issued unchanged.

Reset
REQ-031 While HRESETn=0: HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, RVALID=0, RDATA=0, RERROR=0, CACK=0, A.valid=D.valid=hold=0.
REQ-032 Reset asserted mid-transfer SHALL discard A and D without generating RVALID.

Verification
REQ-033 Single read: CREQ, CADDR=0x100, CWRITE=0, HREADY=1, HRDATA=0xCAFEF00D -> HTRANS=10 one cycle, RVALID with RDATA=0xCAFEF00D, RERROR=0, two cycles after accept.
REQ-034 Back-to-back writes 0x0/0x4 data 0x11/0x22, HREADY=1 -> HTRANS=10 two consecutive cycles, HWDATA=0x11 then 0x22, two RVALID pulses.
REQ-035 Wait states: HREADY=0 for 3 cycles in read data phase -> HADDR/HTRANS of pending next command stable, CACK=0, RVALID delayed 3 cycles.
REQ-036 Error: write 0x8 then read 0xC queued; slave gives HRESP=1/HREADY=0 then HRESP=1/HREADY=1 -> HTRANS=00 in second error cycle, RVALID RERROR=1, read 0xC reissued next cycle and completes OK.
REQ-037 Reset asserted during wait state -> all outputs zero immediately, no RVALID after release, first post-reset command issues normally.

Source files
------------

// File: rtl/ahb_cmd_master_if.sv
// Command-side and AHB-side signal bundle for ahb_cmd_master.
// The master modport is the block's view; the slave modport is the environment's view.
interface ahb_cmd_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  CREQ;
  logic                  CACK;
  logic                  CWRITE;
  logic [ADDR_WIDTH-1:0] CADDR;
  logic [2:0]            CSIZE;
  logic [DATA_WIDTH-1:0] CWDATA;
  logic                  RVALID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic                  RERROR;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic                  HMASTLOCK;
  logic [3:0]            HPROT;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    input  CREQ, CWRITE, CADDR, CSIZE, CWDATA, HRDATA, HREADY, HRESP,
    output CACK, RVALID, RDATA, RERROR,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HPROT, HWDATA
  );

  modport slave (
    output CREQ, CWRITE, CADDR, CSIZE, CWDATA, HRDATA, HREADY, HRESP,
    input  CACK, RVALID, RDATA, RERROR,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HPROT, HWDATA
  );
endinterface

// File: rtl/ahb_cmd_master.sv
// Single-transfer AHB-Lite master fed by a simple command handshake.
// Two-slot pipeline: address-phase slot (p0), data-phase slot (p1), response register (p2).
module ahb_cmd_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahb_cmd_master_if.master bus
);

  logic                  r_vld_p0;
  logic [ADDR_WIDTH-1:0] r_addr_p0;
  logic                  r_write_p0;
  logic [2:0]            r_size_p0;
  logic [DATA_WIDTH-1:0] r_wdata_p0;

  logic                  r_vld_p1;
  logic                  r_write_p1;
  logic [DATA_WIDTH-1:0] r_wdata_p1;

  logic                  r_hold;

  logic                  r_vld_p2;
  logic                  r_rerror_p2;
  logic [DATA_WIDTH-1:0] r_rdata_p2;

  logic                  w_cack;
  logic                  w_a_issue;

  // hold blocks new commands so the retained address phase can be reissued after an ERROR
  assign w_cack    = HRESETn & bus.CREQ & ~r_hold & (~r_vld_p0 | bus.HREADY);
  assign w_a_issue = r_vld_p0 & ~r_hold;

  assign bus.CACK      = w_cack;
  assign bus.HTRANS    = w_a_issue ? 2'b10 : 2'b00;
  assign bus.HADDR     = r_addr_p0;
  assign bus.HWRITE    = r_write_p0;
  assign bus.HSIZE     = r_size_p0;
  assign bus.HWDATA    = r_wdata_p1;
  assign bus.HBURST    = 3'b000;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HPROT     = 4'b0011;
  assign bus.RVALID    = r_vld_p2;
  assign bus.RDATA     = r_rdata_p2;
  assign bus.RERROR    = r_rerror_p2;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_vld_p0    <= 1'b0;
      r_addr_p0   <= '0;
      r_write_p0  <= 1'b0;
      r_size_p0   <= 3'b000;
      r_wdata_p0  <= '0;
      r_vld_p1    <= 1'b0;
      r_write_p1  <= 1'b0;
      r_wdata_p1  <= '0;
      r_hold      <= 1'b0;
      r_vld_p2    <= 1'b0;
      r_rerror_p2 <= 1'b0;
      r_rdata_p2  <= '0;
    end else begin
      // p0: command capture into the address-phase slot
      if (w_cack) begin
        r_vld_p0   <= 1'b1;
        r_addr_p0  <= bus.CADDR;
        r_write_p0 <= bus.CWRITE;
        r_size_p0  <= bus.CSIZE;
        r_wdata_p0 <= bus.CWDATA;
      end else if (bus.HREADY && !r_hold) begin
        r_vld_p0 <= 1'b0;
      end

      // p0 -> p1: address phase accepted, becomes the data phase
      if (bus.HREADY) begin
        r_vld_p1   <= w_a_issue;
        r_write_p1 <= r_write_p0;
        if (w_a_issue) begin
          r_wdata_p1 <= r_wdata_p0;
        end
      end

      if (r_vld_p1 && bus.HRESP && !bus.HREADY) begin
        r_hold <= 1'b1;
      end else if (bus.HREADY) begin
        r_hold <= 1'b0;
      end

      // p1 -> p2: data phase completes, one-cycle response
      if (r_vld_p1 && bus.HREADY) begin
        r_vld_p2    <= 1'b1;
        r_rerror_p2 <= bus.HRESP;
        r_rdata_p2  <= r_write_p1 ? '0 : bus.HRDATA;
      end else begin
        r_vld_p2    <= 1'b0;
        r_rerror_p2 <= 1'b0;
        r_rdata_p2  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Bench for ahb_cmd_master: directed scenarios plus randomized traffic against a
// behavioural AHB slave and in-order response / bus-order scoreboards.
module tb_ahb_cmd_master;
  localparam int DW = 32;
  localparam int AW = 32;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;

  ahb_cmd_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ahb_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    logic [31:0] rdata;
    logic        rerr;
    int          lat;
    int          acc;
  } rsp_t;

  cmd_t bus_q[$];
  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   wait_cfg = 0;
  bit   err_en = 1'b0;

  always @(posedge HCLK) cyc <= cyc + 1;

  // Slave memory image: read data is a fixed function of the address
  function automatic logic [31:0] rd_fn(logic [31:0] a);
    return a ^ 32'hCAFEF10D;
  endfunction

  function automatic bit err_fn(logic [31:0] a);
    return err_en && (a[4:2] == 3'b010);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(logic [31:0] a, logic w, logic [2:0] s, logic [31:0] d, int lat);
    bit ok;
    ok = 1'b0;
    bus.CREQ   = 1'b1;
    bus.CADDR  = a;
    bus.CWRITE = w;
    bus.CSIZE  = s;
    bus.CWDATA = d;
    for (int n = 0; n < 300; n++) begin
      @(negedge HCLK);
      if (bus.CACK) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      bus_q.push_back('{a, w, s, d});
      exp_q.push_back('{(w ? 32'h0 : rd_fn(a)), err_fn(a), lat, cyc + 1});
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: addr %0h never accepted", a);
      bus.CREQ = 1'b0;
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle(int n);
    bus.CREQ = 1'b0;
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic drain();
    idle(1);
    for (int n = 0; n < 1000 && exp_q.size() != 0; n++) begin
      @(posedge HCLK);
      #1;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    idle(2);
  endtask

  task automatic reset_checks();
    check("rst_htrans", 64'(bus.HTRANS), 64'd0);
    check("rst_haddr",  64'(bus.HADDR),  64'd0);
    check("rst_hwrite", 64'(bus.HWRITE), 64'd0);
    check("rst_hsize",  64'(bus.HSIZE),  64'd0);
    check("rst_hwdata", 64'(bus.HWDATA), 64'd0);
    check("rst_rvalid", 64'(bus.RVALID), 64'd0);
    check("rst_rdata",  64'(bus.RDATA),  64'd0);
    check("rst_rerror", 64'(bus.RERROR), 64'd0);
    check("rst_cack",   64'(bus.CACK),   64'd0);
  endtask

  // Behavioural AHB slave: samples address phases, inserts waits and two-cycle ERRORs
  bit          s_dp = 1'b0;
  cmd_t        s_dc;
  int          s_w = 0;
  bit          s_er = 1'b0;
  bit          s_e1 = 1'b0;
  logic        p_rdy = 1'b1;
  logic [1:0]  p_tr = 2'b00;
  logic [31:0] p_addr = 32'h0;

  initial begin
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = 32'h0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        s_dp = 1'b0;
        p_tr = 2'b00;
      end else begin
        if (p_tr == 2'b10 && !p_rdy && bus.HTRANS == 2'b10) begin
          check("haddr_stable", 64'(bus.HADDR), 64'(p_addr));
        end
        if (s_dp && bus.HRESP && bus.HREADY) begin
          check("htrans_idle_in_error", 64'(bus.HTRANS), 64'd0);
        end
        if (s_dp && bus.HREADY) begin
          check("hwdata", 64'(bus.HWDATA), 64'(s_dc.wdata));
          s_dp = 1'b0;
        end
        if (bus.HREADY && bus.HTRANS == 2'b10) begin
          if (bus_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_transfer: addr %0h", bus.HADDR);
          end else begin
            s_dc = bus_q.pop_front();
            check("haddr",  64'(bus.HADDR),  64'(s_dc.addr));
            check("hwrite", 64'(bus.HWRITE), 64'(s_dc.write));
            check("hsize",  64'(bus.HSIZE),  64'(s_dc.size));
            s_dp = 1'b1;
            s_er = err_fn(s_dc.addr);
            s_e1 = 1'b0;
            if (wait_cfg >= 0) s_w = wait_cfg;
            else s_w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
          end
        end
        p_tr   = bus.HTRANS;
        p_rdy  = bus.HREADY;
        p_addr = bus.HADDR;
      end
      @(posedge HCLK);
      #1;
      if (!s_dp) begin
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
      end else if (s_w > 0) begin
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b0;
        s_w--;
      end else if (s_er && !s_e1) begin
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b1;
        s_e1 = 1'b1;
      end else begin
        bus.HREADY = 1'b1;
        bus.HRESP  = s_er;
      end
      bus.HRDATA = s_dp ? rd_fn(s_dc.addr) : $urandom;
    end
  end

  // Response monitor: responses must come back in command order
  initial begin
    rsp_t e;
    forever begin
      @(negedge HCLK);
      if (HRESETn && bus.RVALID) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid: rdata %0h rerror %0b", bus.RDATA, bus.RERROR);
        end else begin
          e = exp_q.pop_front();
          check("rdata",  64'(bus.RDATA),  64'(e.rdata));
          check("rerror", 64'(bus.RERROR), 64'(e.rerr));
          if (e.lat >= 0) check("latency", 64'(cyc - e.acc), 64'(e.lat));
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    bit          seen_wait;
    bus.CREQ   = 1'b1;
    bus.CWRITE = 1'b0;
    bus.CADDR  = 32'h0;
    bus.CSIZE  = 3'b000;
    bus.CWDATA = 32'h0;
    repeat (3) @(posedge HCLK);
    #1;
    reset_checks();
    check("hburst",    64'(bus.HBURST),    64'd0);
    check("hmastlock", 64'(bus.HMASTLOCK), 64'd0);
    check("hprot",     64'(bus.HPROT),     64'h3);
    bus.CREQ = 1'b0;
    HRESETn  = 1'b1;
    idle(2);

    wait_cfg = 0;
    err_en   = 1'b0;
    issue(32'h100, 1'b0, 3'b010, 32'h0, 2);
    drain();

    issue(32'h0, 1'b1, 3'b010, 32'h11, 2);
    issue(32'h4, 1'b1, 3'b010, 32'h22, 2);
    drain();

    wait_cfg = 3;
    issue(32'h200, 1'b0, 3'b010, 32'h0, 5);
    issue(32'h204, 1'b1, 3'b010, 32'h5A5A, -1);
    drain();
    wait_cfg = 0;

    err_en = 1'b1;
    issue(32'h8, 1'b1, 3'b010, 32'hDEAD, -1);
    issue(32'hC, 1'b0, 3'b010, 32'h0, -1);
    drain();
    err_en = 1'b0;

    // Reset in the middle of a wait-stated read: nothing may come back
    wait_cfg = 8;
    issue(32'h300, 1'b0, 3'b010, 32'h0, -1);
    bus.CREQ  = 1'b0;
    seen_wait = 1'b0;
    for (int n = 0; n < 20 && !seen_wait; n++) begin
      @(negedge HCLK);
      seen_wait = !bus.HREADY;
    end
    check("saw_wait_state", 64'(seen_wait), 64'd1);
    #2;
    HRESETn  = 1'b0;
    bus.CREQ = 1'b1;
    #1;
    reset_checks();
    bus.CREQ = 1'b0;
    bus_q.delete();
    exp_q.delete();
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn  = 1'b1;
    wait_cfg = 0;
    idle(8);
    issue(32'h100, 1'b0, 3'b010, 32'h0, 2);
    drain();

    wait_cfg = -1;
    err_en   = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = $urandom & 32'h0000_0FFF;
      issue(a, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, -1);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    drain();

    check("bus_q_empty", 64'(bus_q.size()), 64'd0);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
